// File: rtl/multdiv_seq_pkg.sv
// Shared constants and state encoding for the sequential multiply/divide unit.
package multdiv_seq_pkg;

  localparam int unsigned WIDTH = 32;

  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/multdiv_seq_negate_n.sv
// Parameterised two's-complement negation: bitwise inversion followed by +1.
module negate_n #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a_i,
  output logic [N-1:0] y_o
);

  assign y_o = ~a_i + N'(1);

endmodule

// File: rtl/multdiv_seq.sv
// Sequential signed multiply/divide: one bit per cycle on magnitudes, sign fixed up at the end.
module multdiv_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  import multdiv_seq_pkg::*;

  localparam int unsigned     CntW    = $clog2(ITER);
  localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  // Multiply: {partial product high, remaining multiplier}; divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 neg_q, neg_d;
  logic                 is_div_q, is_div_d;
  logic                 dz_q, dz_d;
  logic                 ovf_q, ovf_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 exc_q, exc_d;
  logic                 rdy_q, rdy_d;
  logic                 busy_q, busy_d;

  logic                 start, start_div;
  logic [WIDTH-1:0]     a_neg, b_neg, a_mag, b_mag;
  logic [WIDTH-1:0]     quo_neg, quo_signed;
  logic [2*WIDTH-1:0]   prod_neg, prod;
  logic [WIDTH:0]       prod_hi;
  logic                 mul_ovf;
  logic [WIDTH-1:0]     mul_addend;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_acc;
  logic [WIDTH:0]       rem_sh, trial;
  logic [2*WIDTH-1:0]   div_acc;

  negate_n #(.N(WIDTH)) u_neg_a (
    .a_i (data_operandA),
    .y_o (a_neg)
  );

  negate_n #(.N(WIDTH)) u_neg_b (
    .a_i (data_operandB),
    .y_o (b_neg)
  );

  negate_n #(.N(WIDTH)) u_neg_quo (
    .a_i (acc_q[WIDTH-1:0]),
    .y_o (quo_neg)
  );

  negate_n #(.N(2 * WIDTH)) u_neg_prod (
    .a_i (acc_q),
    .y_o (prod_neg)
  );

  // Multiply wins when both strobes arrive together.
  assign start     = ctrl_MULT | ctrl_DIV;
  assign start_div = ctrl_DIV & ~ctrl_MULT;

  // INT_MIN negates to itself and is then read as unsigned 2^31.
  assign a_mag = data_operandA[WIDTH-1] ? a_neg : data_operandA;
  assign b_mag = data_operandB[WIDTH-1] ? b_neg : data_operandB;

  always_comb begin
    mul_addend = acc_q[0] ? opb_q : '0;
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    mul_acc    = {mul_sum, acc_q[WIDTH-1:1]};

    rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    trial  = rem_sh - {1'b0, opb_q};
    if (!trial[WIDTH]) begin
      div_acc = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_acc = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    prod       = neg_q ? prod_neg : acc_q;
    prod_hi    = prod[2*WIDTH-1:WIDTH-1];
    mul_ovf    = !((&prod_hi) || !(|prod_hi));
    quo_signed = neg_q ? quo_neg : acc_q[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    busy_d   = (state_q != StIdle);

    case (state_q)
      StMul, StDiv: begin
        acc_d = (state_q == StDiv) ? div_acc : mul_acc;
        if (cnt_q == CntLast) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        rdy_d   = 1'b1;
        if (is_div_q) begin
          result_d = dz_q ? '0 : quo_signed;
          exc_d    = dz_q | ovf_q;
        end else begin
          result_d = prod[WIDTH-1:0];
          exc_d    = mul_ovf;
        end
      end
      default: ;
    endcase

    // A new strobe aborts whatever is in flight, including a pending completion.
    if (start) begin
      state_d  = start_div ? StDiv : StMul;
      cnt_d    = '0;
      rdy_d    = 1'b0;
      result_d = result_q;
      exc_d    = exc_q;
      neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      is_div_d = start_div;
      dz_d     = (data_operandB == '0);
      ovf_d    = (data_operandA == INT_MIN) && (data_operandB == '1);
      if (start_div) begin
        acc_d = {{WIDTH{1'b0}}, a_mag};
        opb_d = b_mag;
      end else begin
        acc_d = {{WIDTH{1'b0}}, b_mag};
        opb_d = a_mag;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule
